// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Central arbiter for a 32-master shared system bus. Issues a
//                one-cycle fixed-priority grant, tracks the granted
//                transaction through begin/end, aborts stalled transfers with
//                a watchdog, and flags idle bus / snoopable SDRAM bursts.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int BEGIN_WAIT     = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] busRequests,
  output logic [31:0] busGrants,
  output logic        busErrorOut,
  output logic        endTransactionOut,
  output logic        busIdle,
  output logic        snoopableBurst,
  input  logic        beginTransactionIn,
  input  logic        endTransactionIn,
  input  logic        dataValidIn,
  input  logic [1:0]  addressDataIn,
  input  logic [7:0]  burstSizeIn
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW_W = $clog2(BEGIN_WAIT + 1);
  // Last count value before the watchdog / begin window expires.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [BW_W-1:0] BW_LAST = BW_W'(BEGIN_WAIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    GRANT      = 3'd1,
    WAIT_BEGIN = 3'd2,
    BUSY       = 3'd3,
    ABORT      = 3'd4
  } state_t;

  state_t          state, state_next;
  logic [WD_W-1:0] wd_cnt, wd_cnt_next;
  logic [BW_W-1:0] bw_cnt, bw_cnt_next;
  logic [31:0]     top_request;
  logic [31:0]     grant_next;
  logic            error_next;
  logic            end_next;
  logic            idle_next;
  logic            snoop_next;

  // Fixed-priority pick: scanning upward lets the highest set bit win.
  always_comb begin
    top_request = '0;
    for (int i = 0; i < 32; i++) begin
      if (busRequests[i]) begin
        top_request    = '0;
        top_request[i] = 1'b1;
      end
    end
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_next  = state;
    wd_cnt_next = wd_cnt;
    bw_cnt_next = bw_cnt;
    grant_next  = '0;
    error_next  = 1'b0;
    end_next    = 1'b0;
    snoop_next  = snoopableBurst;
    case (state)
      IDLE: begin
        if (|busRequests) begin
          state_next = GRANT;
          grant_next = top_request;
        end
      end
      GRANT: begin
        state_next  = WAIT_BEGIN;
        bw_cnt_next = '0;
      end
      WAIT_BEGIN: begin
        if (beginTransactionIn) begin
          state_next  = BUSY;
          wd_cnt_next = '0;
          snoop_next  = (addressDataIn == 2'b00) && (burstSizeIn != 8'd0);
        end else if (bw_cnt == BW_LAST) begin
          // Master forfeited its grant; no error is reported.
          state_next = IDLE;
        end else begin
          bw_cnt_next = bw_cnt + BW_W'(1);
        end
      end
      BUSY: begin
        // End has priority over a watchdog expiry in the same cycle.
        if (endTransactionIn) begin
          state_next = IDLE;
          snoop_next = 1'b0;
        end else if (dataValidIn || beginTransactionIn) begin
          wd_cnt_next = '0;
        end else if (wd_cnt == WD_LAST) begin
          state_next = ABORT;
          error_next = 1'b1;
          end_next   = 1'b1;
          snoop_next = 1'b0;
        end else begin
          wd_cnt_next = wd_cnt + WD_W'(1);
        end
      end
      ABORT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Idle only when parked in IDLE with no grant going out.
    idle_next = (state_next == IDLE);
  end

  // State, counters and all outputs are registered; reset is synchronous.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      wd_cnt            <= '0;
      bw_cnt            <= '0;
      busGrants         <= '0;
      busErrorOut       <= 1'b0;
      endTransactionOut <= 1'b0;
      busIdle           <= 1'b1;
      snoopableBurst    <= 1'b0;
    end else begin
      state             <= state_next;
      wd_cnt            <= wd_cnt_next;
      bw_cnt            <= bw_cnt_next;
      busGrants         <= grant_next;
      busErrorOut       <= error_next;
      endTransactionOut <= end_next;
      busIdle           <= idle_next;
      snoopableBurst    <= snoop_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking directed bench for bus_arbiter. Expected grants
//                are queued when a request is driven and compared when the
//                DUT raises a grant; other outputs are checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clock;
  logic        reset;
  logic [31:0] busRequests;
  logic [31:0] busGrants;
  logic        busErrorOut;
  logic        endTransactionOut;
  logic        busIdle;
  logic        snoopableBurst;
  logic        beginTransactionIn;
  logic        endTransactionIn;
  logic        dataValidIn;
  logic [1:0]  addressDataIn;
  logic [7:0]  burstSizeIn;

  int          total  = 0;
  int          passed = 0;
  logic [31:0] sb[$];

  bus_arbiter #(
    .TIMEOUT_CYCLES(256),
    .BEGIN_WAIT    (4)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .busRequests       (busRequests),
    .busGrants         (busGrants),
    .busErrorOut       (busErrorOut),
    .endTransactionOut (endTransactionOut),
    .busIdle           (busIdle),
    .snoopableBurst    (snoopableBurst),
    .beginTransactionIn(beginTransactionIn),
    .endTransactionIn  (endTransactionIn),
    .dataValidIn       (dataValidIn),
    .addressDataIn     (addressDataIn),
    .burstSizeIn       (burstSizeIn)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: any grant seen must match the oldest queued expectation.
  always @(negedge clock) begin
    logic [31:0] exp_g;
    if (busGrants !== 32'h0) begin
      exp_g = (sb.size() > 0) ? sb.pop_front() : 32'h0;
      check("grant", busGrants, exp_g);
    end
  end

  // Present a request set, expect the given one-hot grant, then withdraw it.
  task automatic grant_cycle(input logic [31:0] req, input logic [31:0] exp);
    busRequests = req;
    sb.push_back(exp);
    tick();
    check("idle_at_grant", 32'(busIdle), 32'd0);
    busRequests = req & ~exp;
    tick();
    check("grant_pulse_done", busGrants, 32'h0);
    check("grant_consumed", sb.size(), 32'd0);
  endtask

  task automatic do_begin(input logic [1:0] addr, input logic [7:0] burst);
    beginTransactionIn = 1'b1;
    addressDataIn      = addr;
    burstSizeIn        = burst;
    tick();
    beginTransactionIn = 1'b0;
  endtask

  task automatic do_end();
    endTransactionIn = 1'b1;
    tick();
    endTransactionIn = 1'b0;
  endtask

  initial begin
    reset              = 1'b0;
    busRequests        = '0;
    beginTransactionIn = 1'b0;
    endTransactionIn   = 1'b0;
    dataValidIn        = 1'b0;
    addressDataIn      = 2'b00;
    burstSizeIn        = 8'd0;

    // Reset held low for three cycles.
    repeat (3) tick();
    check("rst_grants", busGrants, 32'h0);
    check("rst_idle", 32'(busIdle), 32'd1);
    check("rst_err", 32'(busErrorOut), 32'd0);
    check("rst_end", 32'(endTransactionOut), 32'd0);
    check("rst_snoop", 32'(snoopableBurst), 32'd0);
    reset = 1'b1;
    tick();

    // Single master 31: begin, one data beat, end.
    grant_cycle(32'h8000_0000, 32'h8000_0000);
    do_begin(2'b01, 8'd0);
    check("busy_not_idle", 32'(busIdle), 32'd0);
    dataValidIn = 1'b1;
    tick();
    dataValidIn = 1'b0;
    do_end();
    check("end_idle", 32'(busIdle), 32'd1);
    check("end_no_endout", 32'(endTransactionOut), 32'd0);

    // Two requesters: 31 wins, then 0 after at least one idle cycle.
    grant_cycle(32'h8000_0001, 32'h8000_0000);
    do_begin(2'b10, 8'd0);
    do_end();
    check("gap_idle", 32'(busIdle), 32'd1);
    check("gap_no_grant", busGrants, 32'h0);
    grant_cycle(32'h0000_0001, 32'h0000_0001);
    do_begin(2'b11, 8'd3);
    do_end();

    // Snoopable burst: region 00 with non-zero burst.
    grant_cycle(32'h8000_0000, 32'h8000_0000);
    do_begin(2'b00, 8'd7);
    check("snoop_set", 32'(snoopableBurst), 32'd1);
    dataValidIn = 1'b1;
    tick();
    dataValidIn = 1'b0;
    check("snoop_held", 32'(snoopableBurst), 32'd1);
    do_end();
    check("snoop_clr", 32'(snoopableBurst), 32'd0);
    // Other region: not snoopable.
    grant_cycle(32'h8000_0000, 32'h8000_0000);
    do_begin(2'b01, 8'd7);
    check("snoop_region01", 32'(snoopableBurst), 32'd0);
    do_end();
    // Region 00 single beat: not snoopable.
    grant_cycle(32'h0000_0400, 32'h0000_0400);
    do_begin(2'b00, 8'd0);
    check("snoop_single", 32'(snoopableBurst), 32'd0);
    do_end();

    // End strobe in IDLE is ignored.
    do_end();
    check("end_in_idle", 32'(busIdle), 32'd1);

    // Watchdog abort after 256 silent BUSY cycles; master 8 queued meanwhile.
    grant_cycle(32'h8000_0000, 32'h8000_0000);
    do_begin(2'b00, 8'd4);
    busRequests = 32'h0000_0100;
    repeat (255) tick();
    check("wd_not_yet", 32'(busErrorOut), 32'd0);
    tick();
    check("wd_err", 32'(busErrorOut), 32'd1);
    check("wd_endout", 32'(endTransactionOut), 32'd1);
    check("wd_snoop_clr", 32'(snoopableBurst), 32'd0);
    check("wd_not_idle", 32'(busIdle), 32'd0);
    tick();
    check("wd_err_pulse", 32'(busErrorOut), 32'd0);
    check("wd_endout_pulse", 32'(endTransactionOut), 32'd0);
    check("wd_back_idle", 32'(busIdle), 32'd1);

    // Pending master 8 granted, then never begins: forfeits after 4 cycles.
    grant_cycle(32'h0000_0100, 32'h0000_0100);
    repeat (3) tick();
    check("bw_still_waiting", 32'(busIdle), 32'd0);
    tick();
    check("bw_forfeit_idle", 32'(busIdle), 32'd1);
    check("bw_no_err", 32'(busErrorOut), 32'd0);

    // Begin on the last allowed cycle is still accepted; end in WAIT_BEGIN ignored.
    grant_cycle(32'h0000_0020, 32'h0000_0020);
    do_end();
    check("end_in_wait", 32'(busIdle), 32'd0);
    repeat (2) tick();
    do_begin(2'b00, 8'd2);
    check("late_begin_snoop", 32'(snoopableBurst), 32'd1);
    tick();
    check("late_begin_busy", 32'(busIdle), 32'd0);
    do_end();

    // End coinciding with watchdog expiry: end wins, no error.
    grant_cycle(32'h0001_0000, 32'h0001_0000);
    do_begin(2'b00, 8'd5);
    repeat (255) tick();
    do_end();
    check("race_no_err", 32'(busErrorOut), 32'd0);
    check("race_no_endout", 32'(endTransactionOut), 32'd0);
    check("race_idle", 32'(busIdle), 32'd1);

    // Request that drops before it could be granted is never granted.
    grant_cycle(32'h8000_0000, 32'h8000_0000);
    do_begin(2'b01, 8'd1);
    busRequests = 32'h0000_0020;
    tick();
    busRequests = 32'h0;
    do_end();
    repeat (2) tick();
    check("dropped_req_idle", 32'(busIdle), 32'd1);

    // Reset in the middle of a transaction: straight to reset values.
    grant_cycle(32'h8000_0000, 32'h8000_0000);
    do_begin(2'b00, 8'd3);
    check("pre_rst_snoop", 32'(snoopableBurst), 32'd1);
    reset = 1'b0;
    tick();
    check("mid_rst_snoop", 32'(snoopableBurst), 32'd0);
    check("mid_rst_idle", 32'(busIdle), 32'd1);
    check("mid_rst_err", 32'(busErrorOut), 32'd0);
    check("mid_rst_endout", 32'(endTransactionOut), 32'd0);
    reset = 1'b1;
    repeat (2) tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
